batcharger_adc_sequencer: RTL and testbench

- Time-shares the single 8-bit charger ADC between the battery voltage, current and temperature channels.
- Selects the analog mux, waits for settling, starts each conversion and collects the result.
- Publishes registered vbat/ibat/tbat words and the vtok flag to the charger controller.
- Channels are enabled individually by the controller's vmonen/imonen/tmonen outputs.

---
 rtl/batcharger_adc_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_batcharger_adc_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batcharger_adc_sequencer.sv
// Round-robin sequencer sharing the single 8-bit charger ADC between the V/I/T channels.
// Define ADC_AVG_EN to average two back-to-back samples per channel pick.
module batcharger_adc_sequencer #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic       adc_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_STORE  = 3'd4
  } state_e;

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
`ifdef ADC_AVG_EN
  localparam bit AVG_MODE = 1'b1;
`else
  localparam bit AVG_MODE = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic       err_q, err_d;
  logic [7:0] vbat_q, vbat_d;
  logic [7:0] ibat_q, ibat_d;
  logic [7:0] tbat_q, tbat_d;
  logic [2:0] valid_q, valid_d;
  logic       vtok_q, vtok_d;

  logic [2:0] mon_s;
  logic       any_mon_s;
  logic       sel_mon_s;
  logic       cap_s;
  logic       tmo_s;
  logic [7:0] cap_val_s;
`ifdef ADC_AVG_EN
  logic       samp_q, samp_d;
  logic [7:0] s0_q, s0_d;
  logic [8:0] sum_s;
`endif

  function automatic logic [1:0] rr_inc(input logic [1:0] ch);
    rr_inc = (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  // ptr is the first candidate; the search wraps V->I->T->V.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] mon);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_inc(ptr);
    c2 = rr_inc(c1);
    if (mon[ptr]) begin
      rr_pick = ptr;
    end else if (mon[c1]) begin
      rr_pick = c1;
    end else begin
      rr_pick = c2;
    end
  endfunction

  assign mon_s     = {tmonen, imonen, vmonen};
  assign any_mon_s = |mon_s;
  assign sel_mon_s = mon_s[sel_q];
`ifdef ADC_AVG_EN
  assign sum_s     = {1'b0, s0_q} + {1'b0, adc_data};
`endif

  // Next-state, channel pick, settle/timeout counting and start/err pulses.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    cap_s     = 1'b0;
    tmo_s     = 1'b0;
    cap_val_s = adc_data;
`ifdef ADC_AVG_EN
    s0_d      = s0_q;
    cap_val_s = sum_s[8:1];
    if (state_q == S_START || state_q == S_WAIT) begin
      samp_d = samp_q;
    end else begin
      samp_d = 1'b0;
    end
`endif
    if (state_q == S_STORE) begin
      ptr_d = rr_inc(sel_q);
    end else begin
      ptr_d = ptr_q;
    end
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_mon_s) begin
            sel_d   = rr_pick(ptr_q, mon_s);
            cnt_d   = 8'd0;
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SELECT: begin
          if (!sel_mon_s) begin
            state_d = S_STORE;
          end else if (cnt_q == SETTLE_LAST) begin
            start_d = 1'b1;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_START: begin
          if (!sel_mon_s) begin
            state_d = S_STORE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!sel_mon_s) begin
            state_d = S_STORE;
          end else if (adc_done) begin
`ifdef ADC_AVG_EN
            if (!samp_q) begin
              samp_d  = 1'b1;
              s0_d    = adc_data;
              start_d = 1'b1;
              state_d = S_START;
            end else begin
              cap_s   = 1'b1;
              state_d = S_STORE;
            end
`else
            cap_s   = 1'b1;
            state_d = S_STORE;
`endif
          end else if (cnt_q == TIMEOUT_LAST) begin
            tmo_s   = 1'b1;
            err_d   = 1'b1;
            state_d = S_STORE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_STORE: begin
          if (any_mon_s) begin
            sel_d   = rr_pick(rr_inc(sel_q), mon_s);
            cnt_d   = 8'd0;
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Result registers and valid flags; disabling a channel or the sequencer drops its flag.
  always_comb begin
    vbat_d  = vbat_q;
    ibat_d  = ibat_q;
    tbat_d  = tbat_q;
    valid_d = valid_q;
    if (cap_s) begin
      case (sel_q)
        2'd0: begin
          vbat_d     = cap_val_s;
          valid_d[0] = 1'b1;
        end
        2'd1: begin
          ibat_d     = cap_val_s;
          valid_d[1] = 1'b1;
        end
        2'd2: begin
          tbat_d     = cap_val_s;
          valid_d[2] = 1'b1;
        end
        default: valid_d = valid_q;
      endcase
    end else if (tmo_s && !AVG_MODE) begin
      valid_d = valid_q & ~(3'b001 << sel_q);
    end else begin
      valid_d = valid_q;
    end
    valid_d = valid_d & mon_s & {3{en}};
    vtok_d  = valid_d[0] & valid_d[2];
  end

  // State, counters, result registers and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      vbat_q  <= 8'd0;
      ibat_q  <= 8'd0;
      tbat_q  <= 8'd0;
      valid_q <= 3'b000;
      vtok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      err_q   <= err_d;
      vbat_q  <= vbat_d;
      ibat_q  <= ibat_d;
      tbat_q  <= tbat_d;
      valid_q <= valid_d;
      vtok_q  <= vtok_d;
    end
  end

`ifdef ADC_AVG_EN
  // First-sample holding register for the two-sample average.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 1'b0;
      s0_q   <= 8'd0;
    end else begin
      samp_q <= samp_d;
      s0_q   <= s0_d;
    end
  end
`endif

  assign adc_sel   = sel_q;
  assign adc_start = start_q;
  assign vbat      = vbat_q;
  assign ibat      = ibat_q;
  assign tbat      = tbat_q;
  assign vtok      = vtok_q;
  assign adc_err   = err_q;

endmodule

// File: tb/tb_batcharger_adc_sequencer.sv
// Scoreboard bench for batcharger_adc_sequencer: a stimulus process plays the ADC and a
// round-robin channel model; a monitor pops expectations on each DUT start/result/error event.
module tb_batcharger_adc_sequencer;

  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic       clk = 1'b0;
  logic       rst, en, vmonen, imonen, tmonen, adc_done;
  logic [7:0] adc_data;
  logic [1:0] adc_sel;
  logic       adc_start, vtok, adc_err;
  logic [7:0] vbat, ibat, tbat;

  batcharger_adc_sequencer #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc_done(adc_done), .adc_data(adc_data), .adc_sel(adc_sel), .adc_start(adc_start),
    .vbat(vbat), .ibat(ibat), .tbat(tbat), .vtok(vtok), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] v, i, t;
    bit         vt;
  } exp_t;

  exp_t       exp_q[$];
  int         sel_exp_q[$];
  int         errors = 0;
  int         checks = 0;

  logic [7:0] m_reg [3];
  bit         m_val [3];
  bit         m_mask[3];
  int         m_ptr;
  int         cur;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic int pick();
    for (int k = 0; k < 3; k++) begin
      if (m_mask[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return 0;
  endfunction

  function automatic void push_snap(input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.v = m_reg[0];
    e.i = m_reg[1];
    e.t = m_reg[2];
    e.vt = m_val[0] && m_val[2];
    exp_q.push_back(e);
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    adc_done = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_reg[c] = 8'd0;
      m_val[c] = 1'b0;
    end
    m_ptr = 0;
    cyc();
  endtask

  task automatic set_mask(input bit v, input bit i, input bit t);
    vmonen = v; imonen = i; tmonen = t;
    m_mask[0] = v; m_mask[1] = i; m_mask[2] = t;
    for (int c = 0; c < 3; c++) if (!m_mask[c]) m_val[c] = 1'b0;
  endtask

  task automatic end_phase();
    en = 1'b0;
    for (int c = 0; c < 3; c++) m_val[c] = 1'b0;
    repeat (3) cyc();
  endtask

  // Waits for adc_start (checking the current cycle first); a new pick consults the model.
  task automatic wait_start(output int n, input bit new_pick);
    n = 0;
    while (!adc_start && n < 1000) begin
      cyc();
      n++;
    end
    if (!adc_start) begin
      chk("start_seen", adc_start, 1);
      finish_run();
    end
    if (new_pick) cur = pick();
    sel_exp_q.push_back(cur);
  endtask

  task automatic deliver(input int dl, input logic [7:0] d, input bit wr, input logic [7:0] val);
    repeat (dl) cyc();
    adc_done = 1'b1;
    adc_data = d;
    if (wr) begin
      m_reg[cur] = val;
      m_val[cur] = 1'b1;
      m_ptr = (cur + 1) % 3;
    end
    push_snap(1'b0);
    cyc();
    adc_done = 1'b0;
    adc_data = 8'($urandom_range(0, 255));
  endtask

  task automatic time_out();
    int n;
`ifndef ADC_AVG_EN
    m_val[cur] = 1'b0;
`endif
    m_ptr = (cur + 1) % 3;
    push_snap(1'b1);
    n = 0;
    while (!adc_err && n < TMO + 10) begin
      cyc();
      n++;
    end
    chk("err_latency", n, TMO + 1);
  endtask

  task automatic respond(input logic [7:0] d0, input logic [7:0] d1, input int dl, input bit tmo);
`ifdef ADC_AVG_EN
    int n;
    int sum;
    if (tmo) begin
      time_out();
    end else begin
      deliver(dl, d0, 1'b0, 8'd0);
      wait_start(n, 1'b0);
      chk("avg_second_start_gap", n, 0);
      sum = (int'(d0) + int'(d1)) / 2;
      deliver(dl, d1, 1'b1, 8'(sum));
    end
`else
    if (tmo) time_out();
    else deliver(dl, d0, 1'b1, d0);
`endif
  endtask

  task automatic convert(input logic [7:0] d0, input logic [7:0] d1, input int dl, input bit tmo);
    int n;
    wait_start(n, 1'b1);
    respond(d0, d1, dl, tmo);
  endtask

  // Monitor: every start, result edge and error pulse retires one expectation.
  initial begin
    exp_t e;
    int   s;
    bit   prev_done = 1'b0;
    bit   prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (adc_start) begin
          chk("start_expected", int'(sel_exp_q.size() > 0), 1);
          chk("start_single_cycle", int'(prev_start), 0);
          if (sel_exp_q.size() > 0) begin
            s = sel_exp_q.pop_front();
            chk("adc_sel", adc_sel, s);
          end
        end
        if (prev_done || adc_err) begin
          chk("event_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("adc_err_kind", adc_err, e.is_err);
            chk("vbat", vbat, e.v);
            chk("ibat", ibat, e.i);
            chk("tbat", tbat, e.t);
            chk("vtok", vtok, e.vt);
          end
        end
      end
      prev_done = adc_done;
      prev_start = adc_start;
    end
  end

  initial begin
    int n;
    int starts;
    rst = 1'b1; en = 1'b0; adc_done = 1'b0; adc_data = 8'd0;
    set_mask(1'b0, 1'b0, 1'b0);
    do_reset();
    chk("rst_vbat", vbat, 0);
    chk("rst_ibat", ibat, 0);
    chk("rst_tbat", tbat, 0);
    chk("rst_vtok", vtok, 0);
    chk("rst_err", adc_err, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_sel", adc_sel, 0);

    // Voltage only: start latency, single channel back-to-back.
    set_mask(1'b1, 1'b0, 1'b0);
    en = 1'b1;
    wait_start(n, 1'b1);
    chk("start_latency", n - 1, SETTLE + 1);  // first edge sees en and enters SELECT
    respond(8'h99, 8'h99, 3, 1'b0);
    chk("vbat_first", vbat, 8'h99);
    chk("vtok_v_only", vtok, 0);
    convert(8'hC7, 8'hC8, 2, 1'b0);
    chk("vbat_second", vbat, 8'hC7);
    end_phase();

    // All channels: sequence 0,1,2,0 and vtok on the T capture.
    do_reset();
    set_mask(1'b1, 1'b1, 1'b1);
    en = 1'b1;
    convert(8'hA4, 8'hA4, 2, 1'b0);
    convert(8'h66, 8'h66, 4, 1'b0);
    chk("vtok_before_t", vtok, 0);
    convert(8'h64, 8'h64, 1, 1'b0);
    chk("vtok_after_t", vtok, 1);
    chk("vbat_a4", vbat, 8'hA4);
    chk("ibat_66", ibat, 8'h66);
    chk("tbat_64", tbat, 8'h64);
    convert(8'h12, 8'h12, 3, 1'b0);
    end_phase();

    // Timeout on I, then done on the terminal WAIT cycle for T.
    do_reset();
    set_mask(1'b1, 1'b1, 1'b1);
    en = 1'b1;
    convert(8'h55, 8'h55, 2, 1'b0);
    convert(8'h00, 8'h00, 1, 1'b1);
    chk("ibat_after_timeout", ibat, 0);
    convert(8'h3C, 8'h3C, TMO, 1'b0);
    chk("tbat_terminal_done", tbat, 8'h3C);
    end_phase();

    // en dropped during WAIT; late adc_done must be ignored and I re-picked.
    do_reset();
    set_mask(1'b1, 1'b1, 1'b1);
    en = 1'b1;
    convert(8'h21, 8'h21, 2, 1'b0);
    wait_start(n, 1'b1);
    cyc();
    cyc();
    en = 1'b0;
    for (int c = 0; c < 3; c++) m_val[c] = 1'b0;
    cyc();
    cyc();
    adc_done = 1'b1;
    adc_data = 8'hEE;
    push_snap(1'b0);
    cyc();
    adc_done = 1'b0;
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (adc_start) starts++;
    end
    chk("no_start_after_en_drop", starts, 0);
    chk("vtok_after_en_drop", vtok, 0);
    en = 1'b1;
    wait_start(n, 1'b1);
    chk("restart_latency", n - 1, SETTLE + 1);
    respond(8'h77, 8'h77, 2, 1'b0);
    end_phase();

    // tmonen dropped after vtok: flag falls, data holds, sequence becomes 0,1,0,1.
    do_reset();
    set_mask(1'b1, 1'b1, 1'b1);
    en = 1'b1;
    convert(8'h81, 8'h81, 2, 1'b0);
    convert(8'h82, 8'h82, 2, 1'b0);
    convert(8'h83, 8'h83, 2, 1'b0);
    chk("vtok_all_valid", vtok, 1);
    set_mask(1'b1, 1'b1, 1'b0);
    cyc();
    chk("vtok_t_dropped", vtok, 0);
    chk("tbat_holds", tbat, m_reg[2]);
    for (int k = 0; k < 4; k++) convert(8'(8'h10 + k), 8'(8'h10 + k), 2, 1'b0);
    end_phase();

    // Randomized phases against the round-robin model.
    do_reset();
    for (int p = 0; p < 6; p++) begin
      int msk;
      msk = $urandom_range(1, 7);
      set_mask(msk[0], msk[1], msk[2]);
      en = 1'b1;
      for (int k = 0; k < int'($urandom_range(3, 7)); k++) begin
        logic [7:0] d0, d1;
        int dl;
        bit tmo;
        d0 = 8'($urandom_range(0, 255));
        d1 = 8'($urandom_range(0, 255));
        dl = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(1, 6));
        tmo = ($urandom_range(0, 7) == 0);
        convert(d0, d1, dl, tmo);
      end
      end_phase();
    end

    repeat (10) cyc();
    chk("result_queue_drained", exp_q.size(), 0);
    chk("start_queue_drained", sel_exp_q.size(), 0);
    finish_run();
  end

endmodule
